axis_pkt_fifo: RTL and testbench

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

---
 rtl/axis_pkt_fifo_if.sv | 14 +
 rtl/axis_pkt_fifo.sv | 118 +++++++++++
 tb/tb_axis_pkt_fifo.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream beat bundle (tdata/tkeep/tlast/tvalid/tready) shared by
// the upstream and downstream sides of the packet FIFO.
interface axis_pkt_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO: a packet becomes visible only
// once its tlast beat is written; packets larger than the storage are dropped.
module axis_pkt_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  axis_pkt_fifo_if.slave         s_axis,
  axis_pkt_fifo_if.master        m_axis,
  output logic [$clog2(DEPTH):0] fill,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   drop
);
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef enum logic {ACCEPT, DROP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] cnt_q;
  logic             drop_q, drop_d;
  logic             s_ready, wr_en, commit;
  logic [PTR_W-1:0] used, uncommitted;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] rd_entry;
  logic             rd_hs, rd_last;

  assign used        = wr_ptr_q - rd_ptr_q;
  assign uncommitted = wr_ptr_q - wr_commit_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    drop_d      = 1'b0;
    s_ready     = 1'b0;
    wr_en       = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ACCEPT: begin
        // The open packet alone fills storage: it can never commit, so discard it.
        if (uncommitted == DEPTH_P) begin
          s_ready = 1'b1;
          if (s_axis.tvalid) begin
            wr_ptr_d = wr_commit_q;
            if (s_axis.tlast) drop_d = 1'b1;
            else              state_d = DROP;
          end
        end else if (used != DEPTH_P) begin
          s_ready = 1'b1;
          if (s_axis.tvalid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis.tlast) begin
              commit      = 1'b1;
              wr_commit_d = wr_ptr_q + 1'b1;
            end
          end
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          drop_d  = 1'b1;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ACCEPT;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      drop_q      <= drop_d;
      if (rd_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({commit, rd_last})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en && !areset)
      mem[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  assign rd_entry      = mem[rd_ptr_q[AW-1:0]];
  assign m_axis.tvalid = !areset && (cnt_q != '0);
  assign m_axis.tdata  = rd_entry[DATA_W-1:0];
  assign m_axis.tkeep  = rd_entry[DATA_W +: KEEP_W];
  assign m_axis.tlast  = rd_entry[ENT_W-1];
  assign rd_hs         = m_axis.tvalid && m_axis.tready;
  assign rd_last       = rd_hs && m_axis.tlast;

  assign s_axis.tready = s_ready && !areset;
  assign fill          = areset ? '0 : used;
  assign pkt_count     = areset ? '0 : cnt_q;
  assign drop          = drop_q && !areset;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo (DATA_W=32, DEPTH=16): vector table plus
// hand sequences for overflow, exact-fit, backpressure and reset.
module tb_axis_pkt_fifo;
  logic       aclk = 1'b0;
  logic       areset;
  logic [4:0] fill, pkt_count;
  logic       drop;

  axis_pkt_fifo_if #(.DATA_W(32)) s_if ();
  axis_pkt_fifo_if #(.DATA_W(32)) m_if ();

  axis_pkt_fifo #(.DATA_W(32), .DEPTH(16)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .fill      (fill),
    .pkt_count (pkt_count),
    .drop      (drop)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_fail = 0;
  int drop_pulses = 0;
  logic [32:0] exp_q [$];

  always @(posedge aclk) if (drop) drop_pulses++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        sv; logic [31:0] sd; logic [3:0] sk; logic sl; logic mr;
    logic        e_sr; logic e_mv; logic cd; logic [31:0] e_md; logic [3:0] e_mk; logic e_ml;
    logic [4:0]  e_fill; logic [4:0] e_cnt; logic e_drop;
  } vec_t;

  function automatic vec_t mkv(logic sv, logic [31:0] sd, logic [3:0] sk, logic sl, logic mr,
                               logic e_sr, logic e_mv, logic cd, logic [31:0] e_md,
                               logic [3:0] e_mk, logic e_ml, logic [4:0] e_fill, logic [4:0] e_cnt);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sk = sk; v.sl = sl; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.cd = cd; v.e_md = e_md; v.e_mk = e_mk; v.e_ml = e_ml;
    v.e_fill = e_fill; v.e_cnt = e_cnt; v.e_drop = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 32'(i)});
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n, input logic term);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = base + 32'(i);
      s_if.tkeep  = 4'hF;
      s_if.tlast  = term && (i == n - 1);
      @(negedge aclk);
      while (!s_if.tready && w < 200) begin
        @(negedge aclk);
        w++;
      end
      if (w == 200) begin
        chk("send_timeout", 64'(i), 64'(n));
        break;
      end
      tick();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    logic [32:0] e;
    m_if.tready = 1'b1;
    while (got < n && cyc < budget) begin
      @(negedge aclk);
      if (m_if.tvalid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
        chk("drain_beat", {31'h0, m_if.tlast, m_if.tdata}, {31'h0, e});
        got++;
      end
      tick();
      cyc++;
    end
    if (got < n) chk("drain_timeout", 64'(got), 64'(n));
  endtask

  vec_t tbl [15];

  initial begin
    int dp;
    int seen;
    tbl[0]  = mkv(1, 32'hA0, 4'hF, 0, 1,  1, 0, 0, 0,     4'h0, 0, 0, 0);
    tbl[1]  = mkv(1, 32'hA1, 4'h3, 0, 1,  1, 0, 0, 0,     4'h0, 0, 1, 0);
    tbl[2]  = mkv(1, 32'hA2, 4'h1, 1, 1,  1, 0, 0, 0,     4'h0, 0, 2, 0);
    tbl[3]  = mkv(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'hA0, 4'hF, 0, 3, 1);
    tbl[4]  = mkv(0, 32'h0,  4'h0, 0, 0,  1, 1, 1, 32'hA1, 4'h3, 0, 2, 1);
    tbl[5]  = mkv(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'hA1, 4'h3, 0, 2, 1);
    tbl[6]  = mkv(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'hA2, 4'h1, 1, 1, 1);
    tbl[7]  = mkv(0, 32'h0,  4'h0, 0, 1,  1, 0, 0, 0,     4'h0, 0, 0, 0);
    tbl[8]  = mkv(1, 32'hB0, 4'hF, 0, 1,  1, 0, 0, 0,     4'h0, 0, 0, 0);
    tbl[9]  = mkv(1, 32'hB1, 4'hF, 1, 1,  1, 0, 0, 0,     4'h0, 0, 1, 0);
    tbl[10] = mkv(1, 32'hC0, 4'hF, 0, 1,  1, 1, 1, 32'hB0, 4'hF, 0, 2, 1);
    tbl[11] = mkv(1, 32'hC1, 4'hF, 1, 1,  1, 1, 1, 32'hB1, 4'hF, 1, 2, 1);
    tbl[12] = mkv(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'hC0, 4'hF, 0, 2, 1);
    tbl[13] = mkv(0, 32'h0,  4'h0, 0, 1,  1, 1, 1, 32'hC1, 4'hF, 1, 1, 1);
    tbl[14] = mkv(0, 32'h0,  4'h0, 0, 1,  1, 0, 0, 0,     4'h0, 0, 0, 0);

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    areset = 1'b1;
    tick();
    tick();
    @(negedge aclk);
    chk("reset_state", {59'h0, s_if.tready, m_if.tvalid, drop, |fill, |pkt_count}, 64'h0);
    tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", {63'h0, s_if.tready}, 64'h1);
    tick();

    for (int i = 0; i < 15; i++) begin
      s_if.tvalid = tbl[i].sv; s_if.tdata = tbl[i].sd;
      s_if.tkeep  = tbl[i].sk; s_if.tlast = tbl[i].sl;
      m_if.tready = tbl[i].mr;
      @(negedge aclk);
      chk($sformatf("vec%0d", i),
          {s_if.tready, m_if.tvalid,
           tbl[i].cd ? {m_if.tdata, m_if.tkeep, m_if.tlast} : 37'h0,
           fill, pkt_count, drop},
          {tbl[i].e_sr, tbl[i].e_mv,
           tbl[i].cd ? {tbl[i].e_md, tbl[i].e_mk, tbl[i].e_ml} : 37'h0,
           tbl[i].e_fill, tbl[i].e_cnt, tbl[i].e_drop});
      tick();
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;

    // 17-beat oversize packet, then a normal packet behind it
    dp = drop_pulses;
    m_if.tready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'h900 + 32'(i); s_if.tkeep = 4'hF;
      s_if.tlast  = (i == 16);
      @(negedge aclk);
      chk($sformatf("ovf_beat%0d", i), {61'h0, s_if.tready, m_if.tvalid, drop}, 64'h4);
      if (i == 16) chk("ovf_fill16", 64'(fill), 64'd16);
      tick();
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    @(negedge aclk);
    chk("ovf_drop_pulse", {56'h0, drop, m_if.tvalid, 1'b0, fill}, {56'h0, 8'h80});
    tick();
    @(negedge aclk);
    chk("ovf_drop_single", {63'h0, drop}, 64'h0);
    tick();
    chk("ovf_drop_count", 64'(drop_pulses - dp), 64'd1);
    push_pkt(32'h800, 2);
    send_pkt(32'h800, 2, 1'b1);
    drain(2, 20);

    // exactly DEPTH beats: committed, not dropped
    m_if.tready = 1'b0;
    push_pkt(32'h100, 16);
    send_pkt(32'h100, 16, 1'b1);
    @(negedge aclk);
    chk("full16", {52'h0, s_if.tready, m_if.tvalid, 1'b0, fill, 4'h0, pkt_count},
                  {52'h0, 1'b0, 1'b1, 1'b0, 5'd16, 4'h0, 5'd1});
    tick();
    dp = drop_pulses;
    drain(16, 40);
    chk("full16_nodrop", 64'(drop_pulses - dp), 64'd0);
    @(negedge aclk);
    chk("full16_empty", 64'(fill), 64'd0);
    tick();

    // two 8-beat packets fill storage, a third waits for space
    m_if.tready = 1'b0;
    push_pkt(32'h200, 8);
    push_pkt(32'h300, 8);
    send_pkt(32'h200, 8, 1'b1);
    send_pkt(32'h300, 8, 1'b1);
    s_if.tvalid = 1'b1; s_if.tdata = 32'h400; s_if.tkeep = 4'hF; s_if.tlast = 1'b0;
    @(negedge aclk);
    chk("two_pkts_full", {53'h0, s_if.tready, fill, pkt_count}, {53'h0, 1'b0, 5'd16, 5'd2});
    tick();
    push_pkt(32'h400, 4);
    fork
      send_pkt(32'h400, 4, 1'b1);
      drain(20, 200);
    join
    @(negedge aclk);
    chk("drain3_empty", {54'h0, fill, pkt_count}, 64'h0);
    tick();

    // reset with a committed packet and an open packet in storage
    m_if.tready = 1'b0;
    send_pkt(32'h500, 2, 1'b1);
    send_pkt(32'h600, 2, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    chk("reset_mid", {59'h0, s_if.tready, m_if.tvalid, drop, |fill, |pkt_count}, 64'h0);
    tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("post_reset", {52'h0, s_if.tready, m_if.tvalid, fill, pkt_count}, {52'h0, 2'b10, 10'h0});
    tick();
    m_if.tready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (m_if.tvalid) seen++;
      tick();
    end
    chk("no_stale", 64'(seen), 64'd0);
    push_pkt(32'h700, 3);
    send_pkt(32'h700, 3, 1'b1);
    drain(3, 20);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
